// File: rtl/pipelined_adder_n_if.sv
// Stream bundle for pipelined_adder_n: operand beat in, result beat out, each with valid/ready.
interface pipelined_adder_n_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  // Upstream producer / downstream consumer side
  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/pipelined_adder_n.sv
// Pipelined ripple-chunk adder/subtractor: one CW-bit chunk per rank, carry registered between
// ranks, operands skewed so each result leaves the last rank whole. Global stall on backpressure.
module pipelined_adder_n #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic               clk,
  input logic               rst,
  pipelined_adder_n_if.slave bus
);
  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Rank state; the last rank doubles as the output register set
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] cy;
  logic [WIDTH-1:0]  acc [STAGES];
  logic [WIDTH-1:0]  pa  [STAGES];
  logic [WIDTH-1:0]  pb  [STAGES];
  logic              ovf;

  // Inputs seen by each rank (bus for rank 0, predecessor flops otherwise)
  logic [STAGES-1:0] src_v;
  logic [STAGES-1:0] src_c;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_acc [STAGES];

  logic stall;

  assign stall         = vld[LAST] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = vld[LAST];
  assign bus.sum       = acc[LAST];
  assign bus.c_out     = cy[LAST];
  assign bus.overflow  = ovf;

  for (genvar r = 0; r < STAGES; r++) begin : g_rank
    logic [CW:0]      chunk;
    logic [WIDTH-1:0] acc_d;

    if (r == 0) begin : g_src_bus
      // Subtract folds into add: a + ~b + 1, with c_in ignored
      assign src_v[r]   = bus.in_valid;
      assign src_a[r]   = bus.a;
      assign src_b[r]   = bus.sub ? ~bus.b : bus.b;
      assign src_c[r]   = bus.sub | bus.c_in;
      assign src_acc[r] = '0;
    end else begin : g_src_rank
      assign src_v[r]   = vld[r-1];
      assign src_a[r]   = pa[r-1];
      assign src_b[r]   = pb[r-1];
      assign src_c[r]   = cy[r-1];
      assign src_acc[r] = acc[r-1];
    end

    assign chunk = {1'b0, src_a[r][r*CW +: CW]} + {1'b0, src_b[r][r*CW +: CW]}
                 + (CW+1)'(src_c[r]);

    // Splice this rank's chunk into the partially completed result
    always_comb begin
      acc_d               = src_acc[r];
      acc_d[r*CW +: CW]   = chunk[CW-1:0];
    end

    if (r == LAST) begin : g_last
      logic c_msb;
      assign c_msb = src_a[r][WIDTH-1] ^ src_b[r][WIDTH-1] ^ acc_d[WIDTH-1];

      // Result fields only load with a real beat so they hold across bubbles
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld[r] <= 1'b0;
          acc[r] <= '0;
          pa[r]  <= '0;
          pb[r]  <= '0;
          cy[r]  <= 1'b0;
          ovf    <= 1'b0;
        end else if (!stall) begin
          vld[r] <= src_v[r];
          if (src_v[r]) begin
            acc[r] <= acc_d;
            pa[r]  <= src_a[r];
            pb[r]  <= src_b[r];
            cy[r]  <= chunk[CW];
            ovf    <= c_msb ^ chunk[CW];
          end
        end
      end
    end else begin : g_mid
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld[r] <= 1'b0;
          acc[r] <= '0;
          pa[r]  <= '0;
          pb[r]  <= '0;
          cy[r]  <= 1'b0;
        end else if (!stall) begin
          vld[r] <= src_v[r];
          acc[r] <= acc_d;
          pa[r]  <= src_a[r];
          pb[r]  <= src_b[r];
          cy[r]  <= chunk[CW];
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder_n.sv
// Directed bench for pipelined_adder_n at WIDTH=8, STAGES=4: reset, edge sums, subtract,
// streaming, backpressure and reset while beats are in flight.
module tb_pipelined_adder_n;
  localparam int unsigned W = 8;
  localparam int unsigned S = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  pipelined_adder_n_if #(.WIDTH(W)) bus ();

  pipelined_adder_n #(.WIDTH(W), .STAGES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-width reference: {overflow, c_out, sum}
  function automatic logic [9:0] model(input logic [7:0] av, input logic [7:0] bv,
                                       input logic ci, input logic sb);
    logic [7:0] bb;
    logic [8:0] full;
    logic       ov;
    bb   = sb ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + 9'(sb ? 1'b1 : ci);
    ov   = (av[7] == bb[7]) && (full[7] != av[7]);
    return {ov, full[8], full[7:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] av, input logic [7:0] bv,
                       input logic ci, input logic sb);
    bus.in_valid = v;
    bus.a        = av;
    bus.b        = bv;
    bus.c_in     = ci;
    bus.sub      = sb;
  endtask

  // One beat through an idle pipe; reports whether anything showed up early
  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                       input logic sb, output logic early, output logic got_v,
                       output logic [9:0] got);
    early = 1'b0;
    drive(1'b1, av, bv, ci, sb);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    early = early | bus.out_valid;
    step();
    early = early | bus.out_valid;
    step();
    early = early | bus.out_valid;
    step();
    got_v = bus.out_valid;
    got   = {bus.overflow, bus.c_out, bus.sum};
    step();
  endtask

  task automatic test_reset();
    logic [9:0] obs;
    bus.out_ready = 1'b0;
    drive(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    step();
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'hFF) begin
      errors++;
      $display("FAIL pre_reset_beat: valid=%b sum=%h, required valid=1 sum=ff", bus.out_valid, bus.sum);
    end
    #3 rst = 1'b0;
    #1;
    obs = {bus.overflow, bus.c_out, bus.sum};
    checks++;
    if (bus.out_valid !== 1'b0 || obs !== 10'h000 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: valid=%b ovf/c/sum=%h in_ready=%b, required 0 000 1",
               bus.out_valid, obs, bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_held: valid=%b in_ready=%b, required 0 1", bus.out_valid, bus.in_ready);
    end
    rst = 1'b1;
    bus.out_ready = 1'b1;
    step();
  endtask

  task automatic test_add_sub_edges();
    logic [7:0]  ta  [7];
    logic [7:0]  tb  [7];
    logic        tc  [7];
    logic        ts  [7];
    logic [9:0]  te  [7];
    logic        early, got_v;
    logic [9:0]  got;
    // Hand-computed {ovf, c_out, sum}
    ta[0] = 8'hFF; tb[0] = 8'h01; tc[0] = 1'b0; ts[0] = 1'b0; te[0] = {1'b0, 1'b1, 8'h00};
    ta[1] = 8'h7F; tb[1] = 8'h00; tc[1] = 1'b1; ts[1] = 1'b0; te[1] = {1'b1, 1'b0, 8'h80};
    ta[2] = 8'h05; tb[2] = 8'h07; tc[2] = 1'b0; ts[2] = 1'b1; te[2] = {1'b0, 1'b0, 8'hFE};
    ta[3] = 8'h80; tb[3] = 8'h01; tc[3] = 1'b0; ts[3] = 1'b1; te[3] = {1'b1, 1'b1, 8'h7F};
    ta[4] = 8'h05; tb[4] = 8'h07; tc[4] = 1'b1; ts[4] = 1'b1; te[4] = {1'b0, 1'b0, 8'hFE};
    ta[5] = 8'hFF; tb[5] = 8'hFF; tc[5] = 1'b1; ts[5] = 1'b0; te[5] = {1'b0, 1'b1, 8'hFF};
    ta[6] = 8'h80; tb[6] = 8'h80; tc[6] = 1'b0; ts[6] = 1'b0; te[6] = {1'b1, 1'b1, 8'h00};
    for (int i = 0; i < 7; i++) begin
      issue(ta[i], tb[i], tc[i], ts[i], early, got_v, got);
      checks++;
      if (early !== 1'b0 || got_v !== 1'b1 || got !== te[i]) begin
        errors++;
        $display("FAIL edge_vec%0d: early=%b valid=%b ovf/c/sum=%h, required early=0 valid=1 %h",
                 i, early, got_v, got, te[i]);
      end
    end
  endtask

  task automatic test_streaming();
    logic [7:0] va [16];
    logic [7:0] vb [16];
    logic       vc [16];
    logic       vs [16];
    logic [9:0] obs;
    logic       exp_v;
    for (int i = 0; i < 16; i++) begin
      va[i] = 8'(i * 37 + 11);
      vb[i] = 8'(i * 91 + 200);
      vc[i] = 1'(i % 3 == 0);
      vs[i] = 1'((i / 2) % 2);
    end
    bus.out_ready = 1'b1;
    for (int e = 0; e < 20; e++) begin
      if (e < 16) drive(1'b1, va[e], vb[e], vc[e], vs[e]);
      else        drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      step();
      exp_v = (e >= 3) && (e <= 18);
      obs   = {bus.overflow, bus.c_out, bus.sum};
      checks++;
      if (bus.out_valid !== exp_v || bus.in_ready !== 1'b1 ||
          (exp_v && obs !== model(va[e-3], vb[e-3], vc[e-3], vs[e-3]))) begin
        errors++;
        $display("FAIL stream_edge%0d: valid=%b in_ready=%b ovf/c/sum=%h, required valid=%b in_ready=1 %h",
                 e, bus.out_valid, bus.in_ready, obs, exp_v,
                 exp_v ? model(va[e-3], vb[e-3], vc[e-3], vs[e-3]) : 10'h000);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic [9:0] ex [5];
    logic [9:0] obs;
    va[0] = 8'h12; vb[0] = 8'h34;
    va[1] = 8'hF0; vb[1] = 8'h20;
    va[2] = 8'h40; vb[2] = 8'h41;
    va[3] = 8'h01; vb[3] = 8'h02;
    va[4] = 8'hAA; vb[4] = 8'h55;
    for (int i = 0; i < 5; i++) ex[i] = model(va[i], vb[i], 1'b0, 1'b0);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, va[i], vb[i], 1'b0, 1'b0);
      step();
    end
    drive(1'b1, va[4], vb[4], 1'b0, 1'b0);
    for (int h = 0; h < 5; h++) begin
      obs = {bus.overflow, bus.c_out, bus.sum};
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || obs !== ex[0]) begin
        errors++;
        $display("FAIL stall_hold%0d: in_ready=%b valid=%b ovf/c/sum=%h, required 0 1 %h",
                 h, bus.in_ready, bus.out_valid, obs, ex[0]);
      end
      if (h < 4) step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_follow: in_ready=%b, required 1", bus.in_ready);
    end
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      obs = {bus.overflow, bus.c_out, bus.sum};
      checks++;
      if (bus.out_valid !== 1'b1 || obs !== ex[k]) begin
        errors++;
        $display("FAIL drain_beat%0d: valid=%b ovf/c/sum=%h, required 1 %h",
                 k, bus.out_valid, obs, ex[k]);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty: valid=%b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_midflight();
    bus.out_ready = 1'b1;
    drive(1'b1, 8'h11, 8'h22, 1'b0, 1'b0);
    step();
    drive(1'b1, 8'h33, 8'h44, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_in_reset: valid=%b, required 0", bus.out_valid);
    end
    rst = 1'b1;
    drive(1'b1, 8'h10, 8'h20, 1'b0, 1'b0);
    step();
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int e = 0; e < 2; e++) begin
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midflight_ghost%0d: valid=%b sum=%h, required valid=0", e, bus.out_valid, bus.sum);
      end
      step();
    end
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midflight_early: valid=%b, required 0", bus.out_valid);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.sum !== 8'h30 || bus.c_out !== 1'b0) begin
      errors++;
      $display("FAIL midflight_first: valid=%b sum=%h c_out=%b, required 1 30 0",
               bus.out_valid, bus.sum, bus.c_out);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    test_reset();
    test_add_sub_edges();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
